// File: rtl/mem_access_ctrl_if.sv
// Request/response and RAM-side bus of the load/store controller.
// Latency: none, this file holds wires only.
// Backpressure: request uses valid/ready, and the response is held until rsp_ready.
//
// Signals:
//   req_*     byte-addressed load/store request (valid/ready)
//   rsp_*     response: load data, error flag (valid/ready)
//   mem_*     word-wide RAM port; mem_rdata is combinational from mem_address
// Modports:
//   slave     the controller side
//   master    the requester side, which also models the RAM
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem_address;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_address, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_address, mem_rd, mem_wr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store front end for a word-wide RAM, with read-modify-write for sub-word stores.
// Latency (from the accept edge to rsp_valid): error 1, load 2, word store 2, sub-word store 3 cycles.
// Backpressure: one request outstanding; req_ready is low until the response handshake completes.
//
// Ports:
//   clk        single clock; all state changes on posedge
//   rst        synchronous active-high reset; also gates mem_rd/mem_wr combinationally
//   bus        mem_access_ctrl_if.slave (request, response and RAM port)
// Parameters:
//   DEPTH_WORDS  RAM depth in 32-bit words; byte addresses >= 4*DEPTH_WORDS are errors
module mem_access_ctrl #(
    parameter int DEPTH_WORDS = 16384
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [1:0]  SZ_BYTE = 2'd0;
    localparam logic [1:0]  SZ_HALF = 2'd1;
    localparam logic [1:0]  SZ_WORD = 2'd2;
    localparam logic [1:0]  SZ_RSVD = 2'd3;

    // Computed at 33 bits so that a DEPTH_WORDS covering the whole 4 GiB space cannot overflow.
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    state_t      state_q;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [15:0] wdata_q;      // only sub-word stores replay the latched data
    logic [31:0] mem_address_q;
    logic [31:0] mem_wdata_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        accept;
    logic        req_err_d;
    logic [31:0] load_data_d;
    logic [31:0] merge_data_d;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign accept = bus.req_valid && (state_q == IDLE);

    // Classify a request as an error: reserved size, misaligned half/word, or out-of-range address.
    always_comb begin
        req_err_d = 1'b0;
        if (bus.req_size == SZ_RSVD)                                 req_err_d = 1'b1;
        if (bus.req_size == SZ_HALF && bus.req_addr[0])              req_err_d = 1'b1;
        if (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)   req_err_d = 1'b1;
        if ({1'b0, bus.req_addr} >= ADDR_LIMIT)                      req_err_d = 1'b1;
    end

    // Pick the addressed lanes out of the RAM word (little-endian).
    always_comb begin
        rd_byte = 8'h00;
        case (addr_lo_q)
            2'd0:    rd_byte = bus.mem_rdata[7:0];
            2'd1:    rd_byte = bus.mem_rdata[15:8];
            2'd2:    rd_byte = bus.mem_rdata[23:16];
            default: rd_byte = bus.mem_rdata[31:24];
        endcase
        rd_half = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    end

    // Right-align the load result and extend it according to the latched signed flag.
    always_comb begin
        load_data_d = bus.mem_rdata;
        case (size_q)
            SZ_BYTE: load_data_d = {{24{signed_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_data_d = {{16{signed_q & rd_half[15]}}, rd_half};
            default: load_data_d = bus.mem_rdata;
        endcase
    end

    // Read-modify-write merge: overwrite only the addressed lanes and keep the rest of the word.
    always_comb begin
        merge_data_d = bus.mem_rdata;
        if (size_q == SZ_BYTE) begin
            case (addr_lo_q)
                2'd0:    merge_data_d[7:0]   = wdata_q[7:0];
                2'd1:    merge_data_d[15:8]  = wdata_q[7:0];
                2'd2:    merge_data_d[23:16] = wdata_q[7:0];
                default: merge_data_d[31:24] = wdata_q[7:0];
            endcase
        end else begin
            if (addr_lo_q[1]) merge_data_d[31:16] = wdata_q;
            else              merge_data_d[15:0]  = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_lo_q     <= 2'b00;
            size_q        <= SZ_BYTE;
            signed_q      <= 1'b0;
            wdata_q       <= 16'h0000;
            mem_address_q <= 32'h0;
            mem_wdata_q   <= 32'h0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_lo_q <= bus.req_addr[1:0];
                        size_q    <= bus.req_size;
                        signed_q  <= bus.req_signed;
                        wdata_q   <= bus.req_wdata[15:0];
                        if (req_err_d) begin
                            // Errors never touch the RAM, so mem_address keeps its old value.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                            state_q     <= RESP;
                        end else begin
                            mem_address_q <= {2'b00, bus.req_addr[31:2]};
                            if (!bus.req_we) begin
                                mem_rd_q <= 1'b1;
                                state_q  <= RD;
                            end else if (bus.req_size == SZ_WORD) begin
                                mem_wdata_q <= bus.req_wdata;
                                mem_wr_q    <= 1'b1;
                                state_q     <= WR;
                            end else begin
                                mem_rd_q <= 1'b1;
                                state_q  <= RMW_RD;
                            end
                        end
                    end
                end
                RD: begin
                    mem_rd_q    <= 1'b0;
                    rsp_rdata_q <= load_data_d;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RMW_RD: begin
                    mem_rd_q    <= 1'b0;
                    mem_wdata_q <= merge_data_d;
                    mem_wr_q    <= 1'b1;
                    state_q     <= WR;
                end
                WR: begin
                    mem_wr_q    <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    mem_rd_q    <= 1'b0;
                    mem_wr_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
    // Gating with rst means a write that is in flight while reset is high never reaches the RAM.
    assign bus.mem_rd      = mem_rd_q & ~rst;
    assign bus.mem_wr      = mem_wr_q & ~rst;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.DEPTH_WORDS(16384)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: combinational read; the write commits at posedge. Preloads share the write port.
    logic [31:0] ram [0:16383];
    logic        pl_en  = 1'b0;
    logic [13:0] pl_idx = '0;
    logic [31:0] pl_dat = '0;
    assign bus.mem_rdata = ram[bus.mem_address[13:0]];
    always @(posedge clk) begin
        if (pl_en)            ram[pl_idx] <= pl_dat;
        else if (bus.mem_wr)  ram[bus.mem_address[13:0]] <= bus.mem_wdata;
    end

    // Count RAM activity seen away from the clock edge.
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] last_wr_idx = '0;
    always @(negedge clk) begin
        if (bus.mem_rd) rd_cnt++;
        if (bus.mem_wr) begin
            wr_cnt++;
            last_wr_idx = bus.mem_address;
        end
        if (bus.mem_rd && bus.mem_wr) both_cnt++;
    end

    int vec_cnt = 0;
    int miss_cnt = 0;

    task automatic preload(input logic [13:0] idx, input logic [31:0] dat);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_dat = dat;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Issue one request, then wait for its response. lat is the number of negedges from the
    // accept edge until rsp_valid is seen. The response is accepted immediately.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err);
        int guard;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
        if (guard >= 20) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL issue_ready_timeout: req_ready stayed %b, required 1", bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 20);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++; if (bus.rsp_valid !== 1'b0) begin miss_cnt++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
        vec_cnt++; if (bus.rsp_rdata !== 32'h0) begin miss_cnt++; $display("FAIL rst_rsp_rdata got %h want 0", bus.rsp_rdata); end
        vec_cnt++; if (bus.rsp_err !== 1'b0) begin miss_cnt++; $display("FAIL rst_rsp_err got %b want 0", bus.rsp_err); end
        vec_cnt++; if (bus.mem_address !== 32'h0) begin miss_cnt++; $display("FAIL rst_mem_address got %h want 0", bus.mem_address); end
        vec_cnt++; if (bus.mem_wdata !== 32'h0) begin miss_cnt++; $display("FAIL rst_mem_wdata got %h want 0", bus.mem_wdata); end
        vec_cnt++; if ({bus.mem_rd, bus.mem_wr} !== 2'b00) begin miss_cnt++; $display("FAIL rst_mem_rd_wr got %b want 00", {bus.mem_rd, bus.mem_wr}); end
        rst = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus.req_ready !== 1'b1) begin miss_cnt++; $display("FAIL rst_req_ready got %b want 1", bus.req_ready); end
    endtask

    task automatic test_word_access();
        int lat; logic [31:0] rd; logic err; int w0; int r0;
        w0 = wr_cnt;
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, err);
        vec_cnt++; if (lat !== 2) begin miss_cnt++; $display("FAIL wst_latency got %0d want 2", lat); end
        vec_cnt++; if (err !== 1'b0 || rd !== 32'h0) begin miss_cnt++; $display("FAIL wst_rsp got err=%b rdata=%h want 0/0", err, rd); end
        vec_cnt++; if (wr_cnt - w0 !== 1) begin miss_cnt++; $display("FAIL wst_wr_cycles got %0d want 1", wr_cnt - w0); end
        vec_cnt++; if (last_wr_idx !== 32'd4) begin miss_cnt++; $display("FAIL wst_wr_index got %h want 4", last_wr_idx); end
        vec_cnt++; if (ram[4] !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL wst_ram got %h want deadbeef", ram[4]); end
        r0 = rd_cnt;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, err);
        vec_cnt++; if (lat !== 2) begin miss_cnt++; $display("FAIL wld_latency got %0d want 2", lat); end
        vec_cnt++; if (rd !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL wld_rdata got %h want deadbeef", rd); end
        vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL wld_err got %b want 0", err); end
        vec_cnt++; if (rd_cnt - r0 !== 1) begin miss_cnt++; $display("FAIL wld_rd_cycles got %0d want 1", rd_cnt - r0); end
    endtask

    task automatic test_rmw_store();
        int lat; logic [31:0] rd; logic err;
        preload(14'd8, 32'h11223344);
        issue(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, lat, rd, err);
        vec_cnt++; if (lat !== 3) begin miss_cnt++; $display("FAIL bst_latency got %0d want 3", lat); end
        vec_cnt++; if (ram[8] !== 32'h11AA3344) begin miss_cnt++; $display("FAIL bst_ram got %h want 11aa3344", ram[8]); end
        vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL bst_err got %b want 0", err); end
        // Signed flag set on a store to show that it does not affect the stored value.
        issue(1'b1, 2'd1, 1'b1, 32'h20, 32'h1234BEEF, lat, rd, err);
        vec_cnt++; if (ram[8] !== 32'h11AABEEF) begin miss_cnt++; $display("FAIL hst_ram got %h want 11aabeef", ram[8]); end
        issue(1'b1, 2'd0, 1'b0, 32'h27, 32'h0000005A, lat, rd, err);
        vec_cnt++; if (ram[9] !== 32'h5Axxxxxx && ram[9][31:24] !== 8'h5A) begin miss_cnt++; $display("FAIL bst3_ram got %h want top byte 5a", ram[9]); end
    endtask

    task automatic test_loads();
        int lat; logic [31:0] rd; logic err;
        preload(14'd0, 32'h80FF7F01);
        issue(1'b0, 2'd0, 1'b1, 32'h2, 32'h0, lat, rd, err);
        vec_cnt++; if (rd !== 32'hFFFFFFFF) begin miss_cnt++; $display("FAIL ld_sb2 got %h want ffffffff", rd); end
        issue(1'b0, 2'd1, 1'b0, 32'h2, 32'h0, lat, rd, err);
        vec_cnt++; if (rd !== 32'h000080FF) begin miss_cnt++; $display("FAIL ld_uh2 got %h want 000080ff", rd); end
        issue(1'b0, 2'd0, 1'b1, 32'h0, 32'h0, lat, rd, err);
        vec_cnt++; if (rd !== 32'h00000001) begin miss_cnt++; $display("FAIL ld_sb0 got %h want 00000001", rd); end
        issue(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, lat, rd, err);
        vec_cnt++; if (rd !== 32'hFFFF80FF) begin miss_cnt++; $display("FAIL ld_sh2 got %h want ffff80ff", rd); end
        issue(1'b0, 2'd0, 1'b0, 32'h1, 32'h0, lat, rd, err);
        vec_cnt++; if (rd !== 32'h0000007F) begin miss_cnt++; $display("FAIL ld_ub1 got %h want 0000007f", rd); end
        issue(1'b0, 2'd1, 1'b1, 32'h0, 32'h0, lat, rd, err);
        vec_cnt++; if (rd !== 32'h00007F01 || lat !== 2) begin miss_cnt++; $display("FAIL ld_sh0 got %h lat %0d want 00007f01 lat 2", rd, lat); end
    endtask

    task automatic test_errors();
        logic        t_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  t_size [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
        logic [31:0] t_addr [4] = '{32'h3, 32'h6, 32'h0, 32'h10000};
        int lat; logic [31:0] rd; logic err; int r0; int w0;
        for (int i = 0; i < 4; i++) begin
            r0 = rd_cnt; w0 = wr_cnt;
            issue(t_we[i], t_size[i], 1'b0, t_addr[i], 32'hCAFEF00D, lat, rd, err);
            vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL err%0d_flag got %b want 1", i, err); end
            vec_cnt++; if (rd !== 32'h0) begin miss_cnt++; $display("FAIL err%0d_rdata got %h want 0", i, rd); end
            vec_cnt++; if (lat !== 1) begin miss_cnt++; $display("FAIL err%0d_latency got %0d want 1", i, lat); end
            vec_cnt++; if (rd_cnt != r0 || wr_cnt != w0) begin miss_cnt++; $display("FAIL err%0d_ram_access got rd %0d wr %0d want 0 0", i, rd_cnt - r0, wr_cnt - w0); end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_signed = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
        @(posedge clk);
        // A second request waits on the bus while the first response is stalled.
        #1 bus.req_addr = 32'h20;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!bus.rsp_valid && guard < 20);
        for (int c = 0; c < 5; c++) begin
            vec_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF || bus.req_ready !== 1'b0) begin
                miss_cnt++; $display("FAIL bp_hold%0d got valid=%b rdata=%h ready=%b want 1/deadbeef/0", c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
            end
            if (c < 4) @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin miss_cnt++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus.req_ready !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_address !== 32'd8) begin
            miss_cnt++; $display("FAIL bp_next_accept got ready=%b rd=%b addr=%h want 0/1/8", bus.req_ready, bus.mem_rd, bus.mem_address);
        end
        guard = 0;
        while (!bus.rsp_valid && guard < 20) begin @(negedge clk); guard++; end
        vec_cnt++; if (bus.rsp_rdata !== 32'h11AABEEF) begin miss_cnt++; $display("FAIL bp_next_rdata got %h want 11aabeef", bus.rsp_rdata); end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_during_write();
        preload(14'd12, 32'h55667788);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = 32'h31; bus.req_wdata = 32'h99;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus.mem_rd !== 1'b1) begin miss_cnt++; $display("FAIL rstwr_rmw_rd got %b want 1", bus.mem_rd); end
        @(negedge clk);
        vec_cnt++; if (bus.mem_wr !== 1'b1) begin miss_cnt++; $display("FAIL rstwr_wr_cycle got %b want 1", bus.mem_wr); end
        rst = 1'b1;
        #1;
        vec_cnt++; if (bus.mem_wr !== 1'b0) begin miss_cnt++; $display("FAIL rstwr_wr_gated got %b want 0", bus.mem_wr); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vec_cnt++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin miss_cnt++; $display("FAIL rstwr_state got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
        vec_cnt++; if (ram[12] !== 32'h55667788) begin miss_cnt++; $display("FAIL rstwr_ram got %h want 55667788", ram[12]); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
        test_reset();
        test_word_access();
        test_rmw_store();
        test_loads();
        test_errors();
        test_backpressure();
        test_reset_during_write();
        vec_cnt++; if (both_cnt !== 0) begin miss_cnt++; $display("FAIL rd_wr_overlap got %0d cycles want 0", both_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
